rs_issue_arbiter: RTL and testbench
===================================

# rs_issue_arbiter

Per-entry state tracker and oldest-first issue arbiter for the reservation station. It sits between dispatch and execute. It hands dispatch a free entry index, tracks operand readiness through wakeups, and selects one ready entry per cycle for execute under a valid/ready handshake. It frees entries when execute reports retirement on the execute→scheduler channel (`retire_rs_valid` / `retire_rs_entry`).

## Interface
Parameters:
- `RS_ENTRIES`, default `CORE_PKG::RS_ENTRIES` (8): number of RS entries; any value ≥2.
- `IDX_W`, default `$clog2(RS_ENTRIES)`: entry index width.
- `CNT_W`, default `$clog2(RS_ENTRIES+1)`: occupancy width.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `flush` in 1: pipeline flush; clears all entries.
- `alloc_valid` in 1: dispatch requests an entry.
- `alloc_ops_ready` in 1: operands already available at allocation.
- `free_valid` out 1: at least one entry is FREE.
- `free_entry` out IDX_W: lowest-index FREE entry. An allocation occurs when `alloc_valid & free_valid & !flush`.
- `wakeup_valid` in 1: operands of `wakeup_entry` became available.
- `wakeup_entry` in IDX_W: entry being woken.
- `issue_valid` out 1: a READY entry is offered to execute.
- `issue_entry` out IDX_W: oldest READY entry.
- `issue_ready` in 1: execute accepts the offered entry this cycle.
- `retire_rs_valid` in 1: execute finished with `retire_rs_entry`.
- `retire_rs_entry` in IDX_W: entry to free.
- `rs_count` out CNT_W: number of non-FREE entries.
- `err_retire` out 1: sticky; set when a retire targets an entry not in ISSUED.

## Operation
- Each entry has a 2-bit state: FREE → (alloc) WAITING or READY → (wakeup) READY → (issue handshake) ISSUED → (retire) FREE.
- On allocation, the entry goes to READY if `alloc_ops_ready`, otherwise WAITING.
- Wakeup is honoured only when the entry is WAITING. In any other state it is a no-op.
- Exception: wakeup targeting the entry being allocated in the same cycle makes that entry READY.
- Age matrix `older[i][j]` (i allocated before j). Update on allocation of entry k:
  - `older[j][k] = 1` for every non-FREE j.
  - `older[k][*] = 0`.
- Selection:
  - Entry i is chosen when it is READY and no other READY j has `older[j][i]`.
  - The result is one-hot because allocation is limited to one per cycle.
  - `issue_entry` is the encoded index of the chosen entry.
- Transfer on `issue_valid & issue_ready`: the chosen entry becomes ISSUED next cycle. Without `issue_ready`, the offer persists. The offer may change only if an older entry becomes READY.
- Retire moves an ISSUED entry to FREE. A retire to a non-ISSUED entry is ignored and sets `err_retire`.
- Flush has priority over alloc, wakeup, issue and retire:
  - All entries go FREE and the age matrix clears next cycle.
  - `issue_valid` and `free_valid` are forced to 0 in the flush cycle.
  - `err_retire` is not cleared by flush.
- Simultaneous events on different entries (alloc, wakeup, issue, retire) all take effect in the same cycle.
- Alloc and retire cannot collide: `free_entry` is FREE and retire targets ISSUED.
- `rs_count` next value = count + alloc − retire_effective (saturation is impossible by construction). Flush sets it to 0.

## Timing
- Reset (async assert, sync-safe deassert) takes effect immediately on assertion:
  - all entries FREE, age matrix 0, `rs_count` 0, `err_retire` 0;
  - `free_valid` 1, `free_entry` 0, `issue_valid` 0, `issue_entry` 0.
- `free_*`, `issue_*` and `rs_count` are combinational from registered state only. There is no input-to-output combinational path except the `flush` gating.
- Allocation with ops ready → earliest `issue_valid` for that entry is the next cycle (1-cycle latency).
- Wakeup → issue-eligible next cycle.
- Retire → entry visible in `free_entry` next cycle.
- Reset asserted mid-operation discards all state. No pending handshake survives.

## Structure
- `CORE_PKG` holds `RS_ENTRIES` and the typedef `rs_state_e` {RS_FREE, RS_WAITING, RS_READY, RS_ISSUED}.
- The retire inputs connect to the scheduler side of the existing execute→scheduler interface at the top level. This block exposes them as plain ports.
- One sub-module: `rs_age_matrix` (update on alloc, clear on flush, oldest-of-ready-vector output). Priority encoding of free and issue indices stays in the top.

## Test plan
(All scenarios use RS_ENTRIES=8.)
- Reset, then 8 allocs with ops ready, `issue_ready`=0 → `free_entry` 0..7 in order; `free_valid`=0 after the 8th; `rs_count`=8; `issue_entry`=0 held stable.
- Alloc entries 0,1,2 WAITING; wake 2, then 0 in the same cycle as alloc of 3 READY; `issue_ready`=1 → issue order 2, 0, 3. Age beats index.
- Retire entry 0 while `rs_count`=8 and alloc_valid=1 → next cycle `free_entry`=0; following-cycle alloc reuses 0 as youngest; older entries issue first.
- Same-cycle alloc of entry 4 with wakeup_entry=4 and alloc_ops_ready=0 → entry 4 READY; `issue_valid`=1 next cycle.
- Retire of entry 5 while WAITING → state unchanged, `err_retire`=1 and stays 1 through flush.
- Flush with 6 entries in mixed states plus simultaneous alloc and retire → next cycle `rs_count`=0, `issue_valid`=0, `free_entry`=0. Async `rst_n` pulse mid-burst → outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/rs_issue_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// CORE_PKG
// Shared core-level definitions used by the reservation-station issue logic.
//   RS_ENTRIES : default number of reservation-station entries
//   rs_state_e : per-entry lifecycle state FREE -> WAITING/READY -> ISSUED -> FREE
// -----------------------------------------------------------------------------
package CORE_PKG;

    localparam int RS_ENTRIES = 8;

    typedef enum logic [1:0] {
        RS_FREE    = 2'd0,
        RS_WAITING = 2'd1,
        RS_READY   = 2'd2,
        RS_ISSUED  = 2'd3
    } rs_state_e;

endpackage

// File: rtl/rs_issue_arbiter_age.sv
// -----------------------------------------------------------------------------
// rs_age_matrix
// Relative-age tracker for the reservation station. r_older[i][j] = 1 means
// entry i was allocated before entry j. Produces the oldest entry of a
// request vector as a one-hot mask.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_flush       : clear the whole matrix
//   i_alloc_en    : an entry is being allocated this cycle
//   i_alloc_idx   : index of the entry being allocated
//   i_occupied    : entries currently non-FREE (before this cycle's update)
//   i_ready       : candidate vector (READY entries)
//   o_oldest      : one-hot mask of the oldest candidate (0 when none)
// -----------------------------------------------------------------------------
module rs_age_matrix #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_alloc_en,
    input  logic [IDX_W-1:0] i_alloc_idx,
    input  logic [N-1:0]     i_occupied,
    input  logic [N-1:0]     i_ready,
    output logic [N-1:0]     o_oldest
);

    logic [N-1:0][N-1:0] r_older;
    // w_col[i][j] = r_older[j][i]: "j is older than i"
    logic [N-1:0][N-1:0] w_col;

    // The new entry becomes younger than every live entry. Its own row is
    // cleared last so that stale bits from a previous occupant never survive.
    // Stale column bits of freed entries are harmless: a freed entry can only
    // compete again after re-allocation, which rewrites its row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_older <= '0;
        end else if (i_flush) begin
            r_older <= '0;
        end else if (i_alloc_en) begin
            for (int j = 0; j < N; j++) begin
                r_older[j][i_alloc_idx] <= i_occupied[j];
            end
            r_older[i_alloc_idx] <= '0;
        end
    end

    always_comb begin
        w_col = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_col[i][j] = r_older[j][i];
            end
        end
    end

    // A candidate wins when no other candidate is older than it. Live entries
    // form a total order, so at most one bit is set.
    always_comb begin
        o_oldest = '0;
        for (int i = 0; i < N; i++) begin
            o_oldest[i] = i_ready[i] & ~(|(i_ready & w_col[i]));
        end
    end

endmodule

// File: rtl/rs_issue_arbiter.sv
// -----------------------------------------------------------------------------
// rs_issue_arbiter
// Per-entry state tracker and oldest-first issue arbiter for the reservation
// station.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : clear all entries (priority over everything else)
//   alloc_valid           : dispatch requests an entry
//   alloc_ops_ready       : operands available at allocation
//   free_valid/free_entry : lowest-index FREE entry offered to dispatch
//   wakeup_valid/_entry   : operands of a WAITING entry became available
//   issue_valid/_entry    : oldest READY entry offered to execute
//   issue_ready           : execute accepts the offer this cycle
//   retire_rs_valid/_entry: execute finished with an ISSUED entry
//   rs_count              : number of non-FREE entries
//   err_retire            : sticky, retire hit a non-ISSUED entry
//   o_dbg_state           : per-entry state, for observation only
// Handshake: a transfer happens on a rising edge where issue_valid and
// issue_ready are both 1; issue_valid never depends on issue_ready, and an
// unaccepted offer stays put unless an older entry becomes READY.
// -----------------------------------------------------------------------------
module rs_issue_arbiter
    import CORE_PKG::rs_state_e, CORE_PKG::RS_FREE, CORE_PKG::RS_WAITING,
           CORE_PKG::RS_READY, CORE_PKG::RS_ISSUED;
#(
    parameter int RS_ENTRIES = CORE_PKG::RS_ENTRIES,
    parameter int IDX_W      = $clog2(RS_ENTRIES),
    parameter int CNT_W      = $clog2(RS_ENTRIES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        alloc_valid,
    input  logic                        alloc_ops_ready,
    output logic                        free_valid,
    output logic [IDX_W-1:0]            free_entry,
    input  logic                        wakeup_valid,
    input  logic [IDX_W-1:0]            wakeup_entry,
    output logic                        issue_valid,
    output logic [IDX_W-1:0]            issue_entry,
    input  logic                        issue_ready,
    input  logic                        retire_rs_valid,
    input  logic [IDX_W-1:0]            retire_rs_entry,
    output logic [CNT_W-1:0]            rs_count,
    output logic                        err_retire,
    output rs_state_e [RS_ENTRIES-1:0]  o_dbg_state
);

    rs_state_e [RS_ENTRIES-1:0] r_state;
    logic [CNT_W-1:0]           r_count;
    logic                       r_err_retire;

    logic [RS_ENTRIES-1:0] w_free_vec;
    logic [RS_ENTRIES-1:0] w_ready_vec;
    logic [RS_ENTRIES-1:0] w_oldest;
    logic [IDX_W-1:0]      w_free_idx;
    logic [IDX_W-1:0]      w_issue_idx;
    logic                  w_retire_hit;
    logic                  w_alloc;
    logic                  w_issue_fire;
    logic                  w_retire_ok;
    logic                  w_retire_bad;

    always_comb begin
        w_free_vec  = '0;
        w_ready_vec = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_free_vec[i]  = (r_state[i] == RS_FREE);
            w_ready_vec[i] = (r_state[i] == RS_READY);
        end
    end

    rs_age_matrix #(
        .N     (RS_ENTRIES),
        .IDX_W (IDX_W)
    ) u_age (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (flush),
        .i_alloc_en  (w_alloc),
        .i_alloc_idx (w_free_idx),
        .i_occupied  (~w_free_vec),
        .i_ready     (w_ready_vec),
        .o_oldest    (w_oldest)
    );

    // Lowest-index FREE entry (scan from the top so the lowest wins).
    always_comb begin
        w_free_idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (w_free_vec[i]) w_free_idx = IDX_W'(i);
        end
    end

    // w_oldest is one-hot, so any scan order yields the same index.
    always_comb begin
        w_issue_idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (w_oldest[i]) w_issue_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_retire_hit = 1'b0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (retire_rs_entry == IDX_W'(i) && r_state[i] == RS_ISSUED) w_retire_hit = 1'b1;
        end
    end

    // flush is the only input allowed to reach the offer outputs directly.
    assign free_valid   = (|w_free_vec) & ~flush;
    assign free_entry   = w_free_idx;
    assign issue_valid  = (|w_oldest) & ~flush;
    assign issue_entry  = w_issue_idx;
    assign rs_count     = r_count;
    assign err_retire   = r_err_retire;
    assign o_dbg_state  = r_state;

    assign w_alloc      = alloc_valid & free_valid;
    assign w_issue_fire = issue_valid & issue_ready;
    assign w_retire_ok  = retire_rs_valid & w_retire_hit & ~flush;
    assign w_retire_bad = retire_rs_valid & ~w_retire_hit & ~flush;

    // Each event only acts on an entry in one specific state, so events on
    // different entries in the same cycle never conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= {RS_ENTRIES{RS_FREE}};
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (flush) begin
                    r_state[i] <= RS_FREE;
                end else begin
                    case (r_state[i])
                        RS_FREE: begin
                            if (w_alloc && w_free_idx == IDX_W'(i)) begin
                                // A same-cycle wakeup counts as operands ready.
                                if (alloc_ops_ready || (wakeup_valid && wakeup_entry == IDX_W'(i)))
                                    r_state[i] <= RS_READY;
                                else
                                    r_state[i] <= RS_WAITING;
                            end
                        end
                        RS_WAITING: begin
                            if (wakeup_valid && wakeup_entry == IDX_W'(i)) r_state[i] <= RS_READY;
                        end
                        RS_READY: begin
                            if (w_issue_fire && w_issue_idx == IDX_W'(i)) r_state[i] <= RS_ISSUED;
                        end
                        RS_ISSUED: begin
                            if (retire_rs_valid && retire_rs_entry == IDX_W'(i)) r_state[i] <= RS_FREE;
                        end
                        default: r_state[i] <= RS_FREE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_err_retire <= 1'b0;
        end else begin
            if (flush) r_count <= '0;
            else       r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_retire_ok);
            if (w_retire_bad) r_err_retire <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rs_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rs_issue_arbiter
// Directed scenarios plus random traffic for rs_issue_arbiter (8 entries).
// The reference model keeps each entry's state and an allocation sequence
// number; the oldest READY entry is the one with the smallest number.
// Outputs are sampled on the falling edge, inputs change 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_rs_issue_arbiter;

    localparam int N = 8;
    localparam int M_FREE = 0, M_WAITING = 1, M_READY = 2, M_ISSUED = 3;
    localparam logic [12:0] RESET_OUT = 13'b1_000_0_000_0000_0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       alloc_valid = 1'b0;
    logic       alloc_ops_ready = 1'b0;
    logic       free_valid;
    logic [2:0] free_entry;
    logic       wakeup_valid = 1'b0;
    logic [2:0] wakeup_entry = '0;
    logic       issue_valid;
    logic [2:0] issue_entry;
    logic       issue_ready = 1'b0;
    logic       retire_rs_valid = 1'b0;
    logic [2:0] retire_rs_entry = '0;
    logic [3:0] rs_count;
    logic       err_retire;
    logic [15:0] dbg_state;
    logic [12:0] dut_out;

    int checks = 0;
    int failures = 0;

    // reference model
    int m_state[N];
    int m_age[N];
    int m_seq;
    bit m_err;

    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    rs_issue_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .alloc_valid     (alloc_valid),
        .alloc_ops_ready (alloc_ops_ready),
        .free_valid      (free_valid),
        .free_entry      (free_entry),
        .wakeup_valid    (wakeup_valid),
        .wakeup_entry    (wakeup_entry),
        .issue_valid     (issue_valid),
        .issue_entry     (issue_entry),
        .issue_ready     (issue_ready),
        .retire_rs_valid (retire_rs_valid),
        .retire_rs_entry (retire_rs_entry),
        .rs_count        (rs_count),
        .err_retire      (err_retire),
        .o_dbg_state     (dbg_state)
    );

    assign dut_out = {free_valid, free_entry, issue_valid, issue_entry, rs_count, err_retire};

    // ---------------------------------------------------------------- model
    function automatic logic [12:0] model_out();
        logic fv, iv;
        logic [2:0] fe, ie;
        int cnt, best;
        fv = 1'b0; iv = 1'b0; fe = '0; ie = '0; cnt = 0; best = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_state[i] == M_FREE) begin
                fv = 1'b1;
                fe = 3'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m_state[i] != M_FREE) cnt++;
            if (m_state[i] == M_READY) begin
                if (best < 0) best = i;
                else if (m_age[i] < m_age[best]) best = i;
            end
        end
        if (best >= 0) begin
            iv = 1'b1;
            ie = 3'(best);
        end
        if (flush) begin
            fv = 1'b0;
            iv = 1'b0;
        end
        return {fv, fe, iv, ie, 4'(cnt), m_err};
    endfunction

    function automatic logic [15:0] model_states();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[2*i +: 2] = 2'(m_state[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = M_FREE;
            m_age[i] = 0;
        end
        m_seq = 0;
        m_err = 1'b0;
    endtask

    // Apply the current inputs to the model as one clock edge.
    task automatic model_step();
        logic [12:0] e;
        int snap[N];
        int fe, ie, we, re;
        bit alloc, fire;
        e = model_out();
        fe = int'(e[11:9]);
        ie = int'(e[7:5]);
        we = int'(wakeup_entry);
        re = int'(retire_rs_entry);
        alloc = alloc_valid && e[12];
        fire = e[8] && issue_ready;
        if (flush) begin
            for (int i = 0; i < N; i++) m_state[i] = M_FREE;
            return;
        end
        snap = m_state;
        if (retire_rs_valid) begin
            if (snap[re] == M_ISSUED) m_state[re] = M_FREE;
            else m_err = 1'b1;
        end
        if (fire) m_state[ie] = M_ISSUED;
        if (wakeup_valid && snap[we] == M_WAITING) m_state[we] = M_READY;
        if (alloc) begin
            m_state[fe] = (alloc_ops_ready || (wakeup_valid && we == fe)) ? M_READY : M_WAITING;
            m_age[fe] = m_seq;
            m_seq++;
        end
    endtask

    // --------------------------------------------------------------- driver
    task automatic clear_inputs();
        flush = 1'b0;
        alloc_valid = 1'b0;
        alloc_ops_ready = 1'b0;
        wakeup_valid = 1'b0;
        wakeup_entry = '0;
        issue_ready = 1'b0;
        retire_rs_valid = 1'b0;
        retire_rs_entry = '0;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        advance();
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        logic [12:0] e;
        do_reset();
        @(negedge clk);
        e = model_out();
        checks++;
        if (dut_out !== RESET_OUT) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", dut_out, RESET_OUT);
        end
        checks++;
        if (dut_out !== e) begin
            failures++;
            $display("FAIL reset_model got=%b exp=%b", dut_out, e);
        end
        checks++;
        if (dbg_state !== 16'h0000) begin
            failures++;
            $display("FAIL reset_states got=%h exp=0000", dbg_state);
        end
    endtask

    task automatic test_fill();
        logic [12:0] e;
        do_reset();
        for (int i = 0; i < N; i++) begin
            alloc_valid = 1'b1;
            alloc_ops_ready = 1'b1;
            @(negedge clk);
            e = model_out();
            checks++;
            if (dut_out !== e || free_entry !== 3'(i) || free_valid !== 1'b1) begin
                failures++;
                $display("FAIL fill_alloc%0d got=%b exp=%b free_entry_exp=%0d", i, dut_out, e, i);
            end
            if (i > 0) begin
                checks++;
                if (issue_valid !== 1'b1 || issue_entry !== 3'd0) begin
                    failures++;
                    $display("FAIL fill_issue_hold%0d got=%b/%0d exp=1/0", i, issue_valid, issue_entry);
                end
            end
            advance();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (free_valid !== 1'b0 || rs_count !== 4'd8 || issue_valid !== 1'b1 || issue_entry !== 3'd0) begin
            failures++;
            $display("FAIL fill_full got=fv%b cnt%0d iv%b ie%0d exp=fv0 cnt8 iv1 ie0",
                     free_valid, rs_count, issue_valid, issue_entry);
        end
    endtask

    task automatic test_age_order();
        logic [12:0] e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1;
            alloc_ops_ready = 1'b0;
            @(negedge clk);
            e = model_out();
            checks++;
            if (dut_out !== e) begin
                failures++;
                $display("FAIL age_alloc%0d got=%b exp=%b", i, dut_out, e);
            end
            advance();
        end
        clear_inputs();
        wakeup_valid = 1'b1;
        wakeup_entry = 3'd2;
        @(negedge clk);
        checks++;
        if (issue_valid !== 1'b0) begin
            failures++;
            $display("FAIL age_none_ready got=%b exp=0", issue_valid);
        end
        advance();
        // alloc 3 ready, wake 0, accept issues from now on
        alloc_valid = 1'b1;
        alloc_ops_ready = 1'b1;
        wakeup_valid = 1'b1;
        wakeup_entry = 3'd0;
        issue_ready = 1'b1;
        exp_q = '{3'd2, 3'd0, 3'd3};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            e = model_out();
            checks++;
            if (dut_out !== e) begin
                failures++;
                $display("FAIL age_cycle%0d got=%b exp=%b", c, dut_out, e);
            end
            if (issue_valid && issue_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL age_extra_issue got=%0d exp=none", issue_entry);
                end else if (issue_entry !== exp_q[0]) begin
                    failures++;
                    $display("FAIL age_issue_order got=%0d exp=%0d", issue_entry, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            advance();
            alloc_valid = 1'b0;
            wakeup_valid = 1'b0;
        end
        clear_inputs();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL age_missing_issues got=%0d_left exp=0_left", exp_q.size());
        end
    endtask

    task automatic test_retire_reuse();
        logic [12:0] e;
        do_reset();
        alloc_valid = 1'b1;
        alloc_ops_ready = 1'b1;
        repeat (N) advance();
        clear_inputs();
        issue_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (issue_valid !== 1'b1 || issue_entry !== 3'd0) begin
            failures++;
            $display("FAIL reuse_first_issue got=%b/%0d exp=1/0", issue_valid, issue_entry);
        end
        advance();
        clear_inputs();
        retire_rs_valid = 1'b1;
        retire_rs_entry = 3'd0;
        alloc_valid = 1'b1;
        alloc_ops_ready = 1'b1;
        @(negedge clk);
        e = model_out();
        checks++;
        if (dut_out !== e || free_valid !== 1'b0 || rs_count !== 4'd8) begin
            failures++;
            $display("FAIL reuse_full_retire got=%b exp=%b", dut_out, e);
        end
        advance();
        retire_rs_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (free_valid !== 1'b1 || free_entry !== 3'd0 || rs_count !== 4'd7) begin
            failures++;
            $display("FAIL reuse_freed got=fv%b fe%0d cnt%0d exp=fv1 fe0 cnt7", free_valid, free_entry, rs_count);
        end
        advance();
        clear_inputs();
        issue_ready = 1'b1;
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            e = model_out();
            checks++;
            if (dut_out !== e) begin
                failures++;
                $display("FAIL reuse_cycle%0d got=%b exp=%b", c, dut_out, e);
            end
            if (issue_valid && issue_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL reuse_extra_issue got=%0d exp=none", issue_entry);
                end else if (issue_entry !== exp_q[0]) begin
                    failures++;
                    $display("FAIL reuse_issue_order got=%0d exp=%0d", issue_entry, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            advance();
        end
        clear_inputs();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL reuse_missing_issues got=%0d_left exp=0_left", exp_q.size());
        end
    endtask

    // Leaves entries 0..3 WAITING and 4 READY for test_err_flush.
    task automatic test_alloc_wakeup();
        logic [12:0] e;
        do_reset();
        alloc_valid = 1'b1;
        alloc_ops_ready = 1'b0;
        repeat (4) advance();
        wakeup_valid = 1'b1;
        wakeup_entry = 3'd4;
        @(negedge clk);
        checks++;
        if (free_entry !== 3'd4 || issue_valid !== 1'b0) begin
            failures++;
            $display("FAIL aw_pre got=fe%0d iv%b exp=fe4 iv0", free_entry, issue_valid);
        end
        advance();
        clear_inputs();
        @(negedge clk);
        e = model_out();
        checks++;
        if (issue_valid !== 1'b1 || issue_entry !== 3'd4 || dbg_state[9:8] !== 2'd2 || dut_out !== e) begin
            failures++;
            $display("FAIL aw_ready got=iv%b ie%0d st%0d exp=iv1 ie4 st2", issue_valid, issue_entry, dbg_state[9:8]);
        end
    endtask

    task automatic test_err_flush();
        logic [12:0] e;
        // alloc 5 WAITING, issue 4, wake 0
        alloc_valid = 1'b1;
        alloc_ops_ready = 1'b0;
        issue_ready = 1'b1;
        wakeup_valid = 1'b1;
        wakeup_entry = 3'd0;
        advance();
        clear_inputs();
        retire_rs_valid = 1'b1;
        retire_rs_entry = 3'd5;
        @(negedge clk);
        checks++;
        if (err_retire !== 1'b0 || rs_count !== 4'd6) begin
            failures++;
            $display("FAIL err_before got=err%b cnt%0d exp=err0 cnt6", err_retire, rs_count);
        end
        advance();
        clear_inputs();
        @(negedge clk);
        e = model_out();
        checks++;
        if (err_retire !== 1'b1 || dbg_state[11:10] !== 2'd1 || rs_count !== 4'd6 || dut_out !== e) begin
            failures++;
            $display("FAIL err_set got=err%b st5=%0d cnt%0d exp=err1 st5=1 cnt6", err_retire, dbg_state[11:10], rs_count);
        end
        checks++;
        if (dbg_state !== model_states()) begin
            failures++;
            $display("FAIL err_states got=%h exp=%h", dbg_state, model_states());
        end
        // flush with concurrent alloc, retire of issued 4, wakeup and issue accept
        flush = 1'b1;
        alloc_valid = 1'b1;
        alloc_ops_ready = 1'b1;
        retire_rs_valid = 1'b1;
        retire_rs_entry = 3'd4;
        wakeup_valid = 1'b1;
        wakeup_entry = 3'd1;
        issue_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (issue_valid !== 1'b0 || free_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_gate got=iv%b fv%b exp=iv0 fv0", issue_valid, free_valid);
        end
        advance();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (dut_out !== 13'b1_000_0_000_0000_1) begin
            failures++;
            $display("FAIL flush_after got=%b exp=%b", dut_out, 13'b1_000_0_000_0000_1);
        end
        checks++;
        if (dbg_state !== 16'h0000) begin
            failures++;
            $display("FAIL flush_states got=%h exp=0000", dbg_state);
        end
    endtask

    task automatic test_random();
        logic [12:0] e;
        int issued[$];
        do_reset();
        for (int c = 0; c < 600; c++) begin
            flush = ($urandom_range(0, 49) == 0);
            alloc_valid = ($urandom_range(0, 2) != 0);
            alloc_ops_ready = $urandom_range(0, 1);
            wakeup_valid = $urandom_range(0, 1);
            wakeup_entry = 3'($urandom_range(0, N - 1));
            issue_ready = ($urandom_range(0, 2) != 0);
            retire_rs_valid = ($urandom_range(0, 2) == 0);
            issued = {};
            for (int i = 0; i < N; i++) if (m_state[i] == M_ISSUED) issued.push_back(i);
            if (issued.size() > 0 && $urandom_range(0, 15) != 0)
                retire_rs_entry = 3'(issued[$urandom_range(0, issued.size() - 1)]);
            else
                retire_rs_entry = 3'($urandom_range(0, N - 1));
            @(negedge clk);
            e = model_out();
            checks++;
            if (dut_out !== e) begin
                failures++;
                $display("FAIL rand_out%0d got=%b exp=%b", c, dut_out, e);
            end
            checks++;
            if (dbg_state !== model_states()) begin
                failures++;
                $display("FAIL rand_state%0d got=%h exp=%h", c, dbg_state, model_states());
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        logic [12:0] e;
        do_reset();
        alloc_valid = 1'b1;
        alloc_ops_ready = 1'b1;
        issue_ready = 1'b1;
        repeat (5) advance();
        @(negedge clk);
        checks++;
        if (rs_count === 4'd0 || issue_valid !== 1'b1) begin
            failures++;
            $display("FAIL arst_busy got=cnt%0d iv%b exp=cnt>0 iv1", rs_count, issue_valid);
        end
        @(posedge clk);
        model_step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_out !== RESET_OUT || dbg_state !== 16'h0000) begin
            failures++;
            $display("FAIL arst_immediate got=%b exp=%b", dut_out, RESET_OUT);
        end
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        advance();
        @(negedge clk);
        e = model_out();
        checks++;
        if (dut_out !== e || issue_valid !== 1'b0) begin
            failures++;
            $display("FAIL arst_after got=%b exp=%b", dut_out, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #1;
        test_reset();
        test_fill();
        test_age_order();
        test_retire_reuse();
        test_alloc_wakeup();
        test_err_flush();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
